serial_word_aligner: RTL and testbench
======================================

// Module: serial_word_aligner
// PURPOSE
//   Receive-side counterpart of the OSERDESE2 transmit path: a fabric deserializer that takes 1 bit per enabled
//   clock and assembles DATA_WIDTH-bit words (first-received bit -> Q[0], matching D1-first serialization).
//   Word alignment is trained against a known pattern; misalignment is corrected by bitslips.
//   Sits between the pad-side bit sampler and the link-layer word consumer.
// PARAMETERS
//   DATA_WIDTH    8      word width, 2..16
//   TRAIN_PATTERN 8'hB5  DATA_WIDTH-bit training word; must be non-periodic under rotation
//   LOCK_COUNT    4      consecutive matching words required to declare lock, >=1
// PORTS
//   CLK          in   1               single clock, all logic rising-edge
//   RST          in   1               synchronous, active-low reset
//   D            in   1               serial data bit, sampled when CE=1
//   CE           in   1               bit-valid qualifier
//   ALIGN_REQ    in   1               single-cycle pulse: (re)start training
//   Q            out  DATA_WIDTH      last completed word
//   Q_VALID      out  1               1-cycle pulse, Q updated
//   LOCKED       out  1               alignment achieved
//   ALIGN_FAIL   out  1               training exhausted slip budget
//   SLIP_COUNT   out  $clog2(2*DATA_WIDTH)+1  slips issued since last ALIGN_REQ
// BEHAVIOUR
//   Reset (RST=0 at edge): state IDLE; shift reg, bit counter, Q, SLIP_COUNT, match count = 0; all 1-bit outputs 0.
//   Shift: CE=1 -> sr <= {D, sr[W-1:1]}; bit counter advances 0..W-1 and wraps. CE=0 -> everything holds.
//   Word completion: CE=1 with counter=W-1 -> Q <= {D, sr[W-1:1]}; Q_VALID=1 in the next cycle only.
//     Words are output in every state (aligned or not); LOCKED qualifies them.
//   Bitslip: the counter does not advance on the next CE=1 cycle (bit still shifted in);
//     word boundary moves 1 bit later. One slip per decision, never two pending.
//   FSM (compare = word completion evaluated against TRAIN_PATTERN):
//     IDLE:      ALIGN_REQ -> SEARCH.
//     SEARCH:    match -> CONFIRM, match_cnt=1 (LOCKED directly if LOCK_COUNT=1);
//                mismatch -> slip, SLIP_COUNT+1, -> SLIP_WAIT; if SLIP_COUNT already = 2*W -> FAIL, no slip.
//     SLIP_WAIT: next completed word is discarded (not compared) -> SEARCH.
//     CONFIRM:   match -> match_cnt+1, = LOCK_COUNT -> LOCKED; mismatch -> match_cnt=0, slip (same budget rule) -> SLIP_WAIT.
//     LOCKED:    LOCKED=1; no automatic loss-of-lock; holds until ALIGN_REQ or reset.
//     FAIL:      ALIGN_FAIL=1; holds until ALIGN_REQ or reset.
//   ALIGN_REQ in any state: -> SEARCH next cycle; SLIP_COUNT, match_cnt cleared; LOCKED/ALIGN_FAIL drop next cycle;
//     bit counter and shift reg NOT cleared. If coincident with a word completion, ALIGN_REQ wins; word is output but not compared.
//   LOCKED and ALIGN_FAIL are registered, mutually exclusive, assert the cycle after the deciding word completion.
//   Reset mid-operation: immediate return to reset state on that edge; pending slip cancelled.
// TESTING
//   1. RST=0 for 3 cycles, CE=1, D random -> Q=0, Q_VALID=0, LOCKED=0, ALIGN_FAIL=0, SLIP_COUNT=0.
//   2. ALIGN_REQ, then 0xB5 repeated LSB-first, CE=1 -> Q=8'hB5 each 8 cycles, LOCKED=1 after 4th word, SLIP_COUNT=0.
//   3. 3 junk zero bits then 0xB5 repeated -> exactly 3 slips, LOCKED=1, SLIP_COUNT=3, subsequent Q=8'hB5.
//   4. ALIGN_REQ then constant 0x00 -> ALIGN_FAIL=1 after 16 slips, LOCKED=0, SLIP_COUNT=16; ALIGN_REQ clears it.
//   5. Test 3 with CE alternating 1/0 -> identical word sequence, SLIP_COUNT=3, LOCKED=1; no Q_VALID without CE.
//   6. ALIGN_REQ after 2 CONFIRM matches -> match restarts, lock needs 4 more words;
//      RST=0 mid-SEARCH -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/serial_word_aligner.sv
// Fabric deserializer with trained word alignment: assembles LSB-first words from a
// 1-bit stream and walks the word boundary by bitslips until TRAIN_PATTERN is seen.
module serial_word_aligner #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hB5,
  parameter int                    LOCK_COUNT    = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              D,
  input  logic                              CE,
  input  logic                              ALIGN_REQ,
  output logic [DATA_WIDTH-1:0]             Q,
  output logic                              Q_VALID,
  output logic                              LOCKED,
  output logic                              ALIGN_FAIL,
  output logic [$clog2(2*DATA_WIDTH):0]     SLIP_COUNT
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(2*DATA_WIDTH) + 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(2*DATA_WIDTH);
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    SLIP_WAIT,
    CONFIRM,
    LOCK,
    FAIL
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-2:0] sr;
  logic [CW-1:0]         bit_cnt;
  logic [MW-1:0]         match_cnt;
  logic                  slip_pending;

  logic [DATA_WIDTH-1:0] next_word;
  logic                  word_done;
  logic                  match;
  logic [MW-1:0]         match_next;

  always_comb begin
    next_word  = {D, sr};
    word_done  = CE && !slip_pending && (bit_cnt == LAST_BIT);
    match      = (next_word == TRAIN_PATTERN);
    match_next = (state == SEARCH) ? MW'(1) : match_cnt + MW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      match_cnt    <= '0;
      slip_pending <= 1'b0;
      Q            <= '0;
      Q_VALID      <= 1'b0;
      LOCKED       <= 1'b0;
      ALIGN_FAIL   <= 1'b0;
      SLIP_COUNT   <= '0;
    end else begin
      Q_VALID <= 1'b0;

      // A pending slip swallows one enabled bit without advancing the counter,
      // which moves the word boundary one bit later.
      if (CE) begin
        sr <= next_word[DATA_WIDTH-1:1];
        if (slip_pending)
          slip_pending <= 1'b0;
        else if (bit_cnt == LAST_BIT)
          bit_cnt <= '0;
        else
          bit_cnt <= bit_cnt + CW'(1);
      end

      if (word_done) begin
        Q       <= next_word;
        Q_VALID <= 1'b1;
      end

      if (ALIGN_REQ) begin
        state      <= SEARCH;
        SLIP_COUNT <= '0;
        match_cnt  <= '0;
        LOCKED     <= 1'b0;
        ALIGN_FAIL <= 1'b0;
      end else if (word_done) begin
        case (state)
          SEARCH, CONFIRM: begin
            if (match) begin
              match_cnt <= match_next;
              if (match_next == LOCK_N) begin
                state  <= LOCK;
                LOCKED <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end else begin
              match_cnt <= '0;
              if (SLIP_COUNT == SLIP_MAX) begin
                state      <= FAIL;
                ALIGN_FAIL <= 1'b1;
              end else begin
                slip_pending <= 1'b1;
                SLIP_COUNT   <= SLIP_COUNT + SW'(1);
                state        <= SLIP_WAIT;
              end
            end
          end
          SLIP_WAIT: state <= SEARCH;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_aligner.sv
// Directed bench for serial_word_aligner: training, slips, slip-budget failure,
// CE gating, retraining mid-confirm and mid-operation reset.
module tb_serial_word_aligner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       D;
  logic       CE;
  logic       ALIGN_REQ;
  logic [7:0] Q;
  logic       Q_VALID;
  logic       LOCKED;
  logic       ALIGN_FAIL;
  logic [4:0] SLIP_COUNT;

  int checks   = 0;
  int failures = 0;
  int qv_seen  = 0;
  int ce_off_qv = 0;
  logic [7:0] pat = 8'hB5;

  serial_word_aligner #(
    .DATA_WIDTH   (8),
    .TRAIN_PATTERN(8'hB5),
    .LOCK_COUNT   (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .D         (D),
    .CE        (CE),
    .ALIGN_REQ (ALIGN_REQ),
    .Q         (Q),
    .Q_VALID   (Q_VALID),
    .LOCKED    (LOCKED),
    .ALIGN_FAIL(ALIGN_FAIL),
    .SLIP_COUNT(SLIP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic ce);
    D  = b;
    CE = ce;
    @(posedge CLK);
    #1;
    if (Q_VALID) qv_seen++;
    if (!ce && Q_VALID) ce_off_qv++;
  endtask

  task automatic req();
    ALIGN_REQ = 1'b1;
    step(1'b0, 1'b0);
    ALIGN_REQ = 1'b0;
    qv_seen = 0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) step(w[i], 1'b1);
  endtask

  // 3 junk zeros then B5 repeated: boundary is 3 bits late, so 3 slips and
  // lock on the 10th completed word, which ends at stream bit 83.
  task automatic run_slip3(input logic ce_alt, input string tag);
    req();
    ce_off_qv = 0;
    for (int i = 0; i < 83; i++) begin
      step((i < 3) ? 1'b0 : pat[(i-3)%8], 1'b1);
      if (i == 81) chk({tag, "_locked_early"}, LOCKED, 0);
      if (ce_alt) step($urandom_range(0, 1), 1'b0);
    end
    chk({tag, "_locked"}, LOCKED, 1);
    chk({tag, "_slips"}, SLIP_COUNT, 3);
    chk({tag, "_q"}, Q, 8'hB5);
    chk({tag, "_words"}, qv_seen, 10);
    chk({tag, "_fail"}, ALIGN_FAIL, 0);
    chk({tag, "_qv_without_ce"}, ce_off_qv, 0);
  endtask

  initial begin
    RST = 1'b0; D = 1'b0; CE = 1'b1; ALIGN_REQ = 1'b0;

    // 1: reset with live CE and random data
    for (int i = 0; i < 3; i++) step($urandom_range(0, 1), 1'b1);
    chk("rst_q", Q, 0);
    chk("rst_qvalid", Q_VALID, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_fail", ALIGN_FAIL, 0);
    chk("rst_slips", SLIP_COUNT, 0);
    RST = 1'b1;

    // 2: already aligned stream
    req();
    chk("t2_slips0", SLIP_COUNT, 0);
    for (int w = 0; w < 3; w++) send_word(8'hB5);
    chk("t2_locked_after3", LOCKED, 0);
    chk("t2_q3", Q, 8'hB5);
    send_word(8'hB5);
    chk("t2_locked_after4", LOCKED, 1);
    chk("t2_qvalid_pulse", Q_VALID, 1);
    chk("t2_words", qv_seen, 4);
    chk("t2_slips", SLIP_COUNT, 0);

    // 3: three-bit misalignment
    run_slip3(1'b0, "t3");

    // 4: no pattern ever; 17 compared words + 16 discarded + 16 slip bits = 280
    req();
    chk("t4_qvalid_gap", Q_VALID, 0);
    chk("t4_locked_drop", LOCKED, 0);
    chk("t4_slips_clr", SLIP_COUNT, 0);
    for (int i = 0; i < 279; i++) step(1'b0, 1'b1);
    chk("t4_fail_early", ALIGN_FAIL, 0);
    chk("t4_slips_pre", SLIP_COUNT, 16);
    step(1'b0, 1'b1);
    chk("t4_fail", ALIGN_FAIL, 1);
    chk("t4_locked", LOCKED, 0);
    chk("t4_slips", SLIP_COUNT, 16);
    req();
    chk("t4_fail_clr", ALIGN_FAIL, 0);
    chk("t4_slips_reclr", SLIP_COUNT, 0);

    // 5: same misalignment with CE toggling
    run_slip3(1'b1, "t5");

    // 6: retrain after two confirming matches
    req();
    send_word(8'hB5);
    send_word(8'hB5);
    req();
    chk("t6_locked_req", LOCKED, 0);
    for (int w = 0; w < 3; w++) send_word(8'hB5);
    chk("t6_locked_after3", LOCKED, 0);
    send_word(8'hB5);
    chk("t6_locked_after4", LOCKED, 1);

    // reset in the middle of SEARCH
    req();
    for (int i = 0; i < 3; i++) step(pat[i], 1'b1);
    RST = 1'b0;
    step(1'b1, 1'b1);
    RST = 1'b1;
    chk("t6_rst_q", Q, 0);
    chk("t6_rst_qvalid", Q_VALID, 0);
    chk("t6_rst_locked", LOCKED, 0);
    chk("t6_rst_fail", ALIGN_FAIL, 0);
    chk("t6_rst_slips", SLIP_COUNT, 0);
    // IDLE after reset: words still emitted but never trained
    for (int w = 0; w < 4; w++) send_word(8'hB5);
    chk("t6_idle_q", Q, 8'hB5);
    chk("t6_idle_locked", LOCKED, 0);
    chk("t6_idle_slips", SLIP_COUNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
